id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage, directly downstream of the 32x32 register file.
- Captures rs1/rs2 operand data read from the register file in the same cycle, plus decoded fields from IF/ID.
- Resolves operand bypass from the MEM and WB stages and detects load-use hazards, inserting a one-cycle bubble.
- Presents registered operands and controls to the EX stage.

---
 rtl/id_ex_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
//==============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute pipeline register. Captures the register
//               file read data and the decoded IF/ID fields. Resolves operand
//               bypass from MEM (highest priority) and WB. Detects load-use
//               hazards and inserts a one-cycle bubble.
// Optional    : ID_EX_PERF_CNT_EN adds a 32-bit stall_cnt output. It counts
//               the clock edges on which stall_out is high.
// Ports       : clk, rst (async, active-high)
//               id_*      decoded instruction from IF/ID
//               rf_data_* register-file read data for id_rs1 / id_rs2
//               mem_*     MEM-stage writeback bypass source
//               wb_*      WB-stage writeback bypass source
//               flush     kill the instruction currently in ID
//               stall_out hold PC and IF/ID (combinational)
//               ex_*      registered operands and controls for EX
// Revision    : 1.0 - initial release
//==============================================================================
module id_ex_stage #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REGADDR_W-1:0] id_rs1,
   input  logic [REGADDR_W-1:0] id_rs2,
   input  logic [REGADDR_W-1:0] id_rd,
   input  logic                 id_regwen,
   input  logic                 id_memread,
   input  logic [XLEN-1:0]      id_imm,
   input  logic [XLEN-1:0]      id_pc,
   input  logic [XLEN-1:0]      rf_data_a,
   input  logic [XLEN-1:0]      rf_data_b,
   input  logic [REGADDR_W-1:0] mem_rd,
   input  logic                 mem_regwen,
   input  logic [XLEN-1:0]      mem_data,
   input  logic [REGADDR_W-1:0] wb_rd,
   input  logic                 wb_regwen,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 flush,
   output logic                 stall_out,
   output logic                 ex_valid,
   output logic [XLEN-1:0]      ex_opa,
   output logic [XLEN-1:0]      ex_opb,
   output logic [REGADDR_W-1:0] ex_rs1,
   output logic [REGADDR_W-1:0] ex_rs2,
   output logic [REGADDR_W-1:0] ex_rd,
   output logic                 ex_regwen,
   output logic                 ex_memread,
   output logic [XLEN-1:0]      ex_imm,
   output logic [XLEN-1:0]      ex_pc
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   localparam logic [REGADDR_W-1:0] c_X0 = '0;

   // Registered EX-stage state
   logic                 ex_valid_q,   ex_valid_d;
   logic                 ex_regwen_q,  ex_regwen_d;
   logic                 ex_memread_q, ex_memread_d;
   logic [XLEN-1:0]      ex_opa_q,     ex_opa_d;
   logic [XLEN-1:0]      ex_opb_q,     ex_opb_d;
   logic [REGADDR_W-1:0] ex_rs1_q,     ex_rs1_d;
   logic [REGADDR_W-1:0] ex_rs2_q,     ex_rs2_d;
   logic [REGADDR_W-1:0] ex_rd_q,      ex_rd_d;
   logic [XLEN-1:0]      ex_imm_q,     ex_imm_d;
   logic [XLEN-1:0]      ex_pc_q,      ex_pc_d;

   logic                 w_hazard;
   logic                 w_bubble;
   logic [XLEN-1:0]      w_opa;
   logic [XLEN-1:0]      w_opb;

   // Operand bypass. x0 always reads zero. MEM is the younger producer, so it
   // wins over WB. WB must be bypassed because the register file writes on
   // negedge and its read port does not re-evaluate on a data change.
   function automatic logic [XLEN-1:0] f_resolve(
      input logic [REGADDR_W-1:0] rs,
      input logic [XLEN-1:0]      rf,
      input logic [REGADDR_W-1:0] m_rd,
      input logic                 m_wen,
      input logic [XLEN-1:0]      m_data,
      input logic [REGADDR_W-1:0] w_rd,
      input logic                 w_wen,
      input logic [XLEN-1:0]      w_data
   );
      if (rs == c_X0)
         return '0;
      else if (m_wen && (m_rd == rs))
         return m_data;
      else if (w_wen && (w_rd == rs))
         return w_data;
      else
         return rf;
   endfunction

   always_comb begin
      w_opa = f_resolve(id_rs1, rf_data_a, mem_rd, mem_regwen, mem_data,
                        wb_rd, wb_regwen, wb_data);
      w_opb = f_resolve(id_rs2, rf_data_b, mem_rd, mem_regwen, mem_data,
                        wb_rd, wb_regwen, wb_data);
   end

   // A load still in EX has no data yet. A consumer in ID must wait one
   // cycle, until the load reaches MEM and the MEM bypass covers it.
   assign w_hazard = id_valid && ex_valid_q && ex_memread_q &&
                     (ex_rd_q != c_X0) &&
                     ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

   // rst is included so that stall_out falls at once with an async reset,
   // independent of when the registers settle.
   assign stall_out = w_hazard && !flush && !rst;

   // Both a flush and a hazard leave EX empty. Data fields load anyway,
   // because only the qualifying controls matter on a bubble.
   assign w_bubble = flush || w_hazard;

   always_comb begin
      ex_valid_d   = id_valid  && !w_bubble;
      ex_regwen_d  = id_regwen  && id_valid && !w_bubble;
      ex_memread_d = id_memread && id_valid && !w_bubble;
      ex_opa_d     = w_opa;
      ex_opb_d     = w_opb;
      ex_rs1_d     = id_rs1;
      ex_rs2_d     = id_rs2;
      ex_rd_d      = id_rd;
      ex_imm_d     = id_imm;
      ex_pc_d      = id_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_regwen_q  <= 1'b0;
         ex_memread_q <= 1'b0;
         ex_opa_q     <= '0;
         ex_opb_q     <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_rd_q      <= '0;
         ex_imm_q     <= '0;
         ex_pc_q      <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_regwen_q  <= ex_regwen_d;
         ex_memread_q <= ex_memread_d;
         ex_opa_q     <= ex_opa_d;
         ex_opb_q     <= ex_opb_d;
         ex_rs1_q     <= ex_rs1_d;
         ex_rs2_q     <= ex_rs2_d;
         ex_rd_q      <= ex_rd_d;
         ex_imm_q     <= ex_imm_d;
         ex_pc_q      <= ex_pc_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_regwen  = ex_regwen_q;
   assign ex_memread = ex_memread_q;
   assign ex_opa     = ex_opa_q;
   assign ex_opb     = ex_opb_q;
   assign ex_rs1     = ex_rs1_q;
   assign ex_rs2     = ex_rs2_q;
   assign ex_rd      = ex_rd_q;
   assign ex_imm     = ex_imm_q;
   assign ex_pc      = ex_pc_q;

`ifdef ID_EX_PERF_CNT_EN
   // Free-running stall counter. It wraps naturally at 2^32.
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = stall_out ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_id_ex_stage
// Description : Directed scoreboard bench for id_ex_stage. Each driven cycle
//               pushes the hand-computed EX-stage contents expected after the
//               next clock edge. A monitor pops one entry after every edge
//               and compares it.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_id_ex_stage;

   typedef struct packed {
      logic        v;
      logic [4:0]  rs1, rs2, rd;
      logic        regwen, memread;
      logic [31:0] imm, pc, rfa, rfb;
      logic [4:0]  mrd;
      logic        mwen;
      logic [31:0] mdata;
      logic [4:0]  wrd;
      logic        wwen;
      logic [31:0] wdata;
      logic        flush;
   } stim_t;

   typedef struct packed {
      logic        v, regwen, memread, chk;
      logic [31:0] opa, opb;
      logic [4:0]  rd;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_regwen, id_memread;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_imm, id_pc, rf_data_a, rf_data_b;
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_regwen, wb_regwen;
   logic [31:0] mem_data, wb_data;
   logic        flush;
   logic        stall_out, ex_valid, ex_regwen, ex_memread;
   logic [31:0] ex_opa, ex_opb, ex_imm, ex_pc;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .REGADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_regwen(id_regwen), .id_memread(id_memread),
      .id_imm(id_imm), .id_pc(id_pc),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_data(mem_data),
      .wb_rd(wb_rd), .wb_regwen(wb_regwen), .wb_data(wb_data),
      .flush(flush), .stall_out(stall_out),
      .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwen(ex_regwen), .ex_memread(ex_memread),
      .ex_imm(ex_imm), .ex_pc(ex_pc)
`ifdef ID_EX_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic exp_t mke(input logic v, input logic rw, input logic mr,
                                input logic c, input logic [31:0] opa,
                                input logic [31:0] opb, input logic [4:0] rd,
                                input logic [31:0] pc);
      exp_t e;
      e.v = v; e.regwen = rw; e.memread = mr; e.chk = c;
      e.opa = opa; e.opb = opb; e.rd = rd; e.pc = pc;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      id_valid = s.v;  id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
      id_regwen = s.regwen; id_memread = s.memread;
      id_imm = s.imm; id_pc = s.pc; rf_data_a = s.rfa; rf_data_b = s.rfb;
      mem_rd = s.mrd; mem_regwen = s.mwen; mem_data = s.mdata;
      wb_rd = s.wrd; wb_regwen = s.wwen; wb_data = s.wdata;
      flush = s.flush;
   endtask

   // Called at posedge+2. Drives one ID cycle, checks the combinational
   // stall, and queues the EX contents expected after the coming edge.
   task automatic apply(input string name, input stim_t s, input logic stall, input exp_t e);
      drive(s);
      #1;
      chk({name, ".stall_out"}, {31'd0, stall_out}, {31'd0, stall});
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected entry per clock edge while the queue is loaded.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_valid",   {31'd0, ex_valid},   {31'd0, e.v});
            chk("ex_regwen",  {31'd0, ex_regwen},  {31'd0, e.regwen});
            chk("ex_memread", {31'd0, ex_memread}, {31'd0, e.memread});
            if (e.chk) begin
               chk("ex_opa", ex_opa, e.opa);
               chk("ex_opb", ex_opb, e.opb);
               chk("ex_rd",  {27'd0, ex_rd}, {27'd0, e.rd});
               chk("ex_pc",  ex_pc, e.pc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      stim_t lw7;
      stim_t dep7;

      rst = 1'b1;
      drive(idle());
      @(posedge clk);
      #2;
      chk("reset.ex_valid",  {31'd0, ex_valid},  32'd0);
      chk("reset.stall_out", {31'd0, stall_out}, 32'd0);
      chk("reset.ex_pc",     ex_pc, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Plain pass-through
      s = idle(); s.v = 1; s.rs1 = 3; s.rfa = 32'h11; s.rs2 = 4; s.rfb = 32'h22;
      s.rd = 8; s.regwen = 1; s.pc = 32'h1000;
      apply("pass", s, 0, mke(1, 1, 0, 1, 32'h11, 32'h22, 8, 32'h1000));

      // MEM bypass beats WB bypass
      s = idle(); s.v = 1; s.rs1 = 5; s.rfa = 32'h55; s.rs2 = 6; s.rfb = 32'h66;
      s.rd = 9; s.regwen = 1; s.pc = 32'h1004;
      s.mrd = 5; s.mwen = 1; s.mdata = 32'hAAAA;
      s.wrd = 5; s.wwen = 1; s.wdata = 32'hBBBB;
      apply("byp_mem", s, 0, mke(1, 1, 0, 1, 32'hAAAA, 32'h66, 9, 32'h1004));

      // MEM disabled, WB takes over
      s.mwen = 0; s.pc = 32'h1008;
      apply("byp_wb", s, 0, mke(1, 1, 0, 1, 32'hBBBB, 32'h66, 9, 32'h1008));

      // rs1 = x0 ignores the register file and both bypass sources
      s = idle(); s.v = 1; s.rs1 = 0; s.rfa = 32'h99; s.rs2 = 6; s.rfb = 32'h66;
      s.rd = 9; s.regwen = 1; s.pc = 32'h100C;
      s.mrd = 0; s.mwen = 1; s.mdata = 32'hAAAA;
      s.wrd = 0; s.wwen = 1; s.wdata = 32'hBBBB;
      apply("x0_src", s, 0, mke(1, 1, 0, 1, 32'h0, 32'h66, 9, 32'h100C));

      // WB bypass on operand B
      s = idle(); s.v = 1; s.rs1 = 3; s.rfa = 32'h11; s.rs2 = 9; s.rfb = 32'h99;
      s.rd = 10; s.regwen = 1; s.pc = 32'h1010;
      s.wrd = 9; s.wwen = 1; s.wdata = 32'h1234;
      apply("byp_wb_b", s, 0, mke(1, 1, 0, 1, 32'h11, 32'h1234, 10, 32'h1010));

      // Load-use: LW x7 then ADD x9,x3,x7 -> one stall, one bubble
      lw7 = idle(); lw7.v = 1; lw7.rs1 = 2; lw7.rfa = 32'h200; lw7.rd = 7;
      lw7.regwen = 1; lw7.memread = 1; lw7.pc = 32'h1014;
      apply("lw7", lw7, 0, mke(1, 1, 1, 1, 32'h200, 32'h0, 7, 32'h1014));
      dep7 = idle(); dep7.v = 1; dep7.rs1 = 3; dep7.rfa = 32'h11; dep7.rs2 = 7;
      dep7.rfb = 32'hDEAD; dep7.rd = 9; dep7.regwen = 1; dep7.pc = 32'h1018;
      apply("lu_stall", dep7, 1, mke(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt_one", stall_cnt, 32'd1);
`endif
      // Re-presented ADD: load now in MEM, so no second stall
      s = dep7; s.mrd = 7; s.mwen = 1; s.mdata = 32'hCAFE;
      apply("lu_replay", s, 0, mke(1, 1, 0, 1, 32'h11, 32'hCAFE, 9, 32'h1018));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt_still_one", stall_cnt, 32'd1);
`endif

      // Flush beats stall
      s = idle(); s.v = 1; s.rs1 = 2; s.rfa = 32'h200; s.rd = 10; s.regwen = 1;
      s.memread = 1; s.pc = 32'h101C;
      apply("lw10", s, 0, mke(1, 1, 1, 1, 32'h200, 32'h0, 10, 32'h101C));
      s = idle(); s.v = 1; s.rs1 = 10; s.rd = 11; s.regwen = 1; s.flush = 1;
      s.pc = 32'h1020;
      apply("flush_hz", s, 0, mke(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));

      // x0 load never stalls its rs1=x0 consumer
      s = idle(); s.v = 1; s.rs1 = 2; s.rfa = 32'h200; s.rd = 0; s.regwen = 1;
      s.memread = 1; s.pc = 32'h1024;
      apply("lw0", s, 0, mke(1, 1, 1, 1, 32'h200, 32'h0, 0, 32'h1024));
      s = idle(); s.v = 1; s.rs1 = 0; s.rfa = 32'h77; s.rd = 12; s.regwen = 1;
      s.pc = 32'h1028;
      apply("x0_use", s, 0, mke(1, 1, 0, 1, 32'h0, 32'h0, 12, 32'h1028));

      // Invalid ID must not carry regwen/memread into EX, so no later stall
      s = idle(); s.v = 0; s.rd = 5; s.regwen = 1; s.memread = 1; s.pc = 32'h102C;
      apply("inv_id", s, 0, mke(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
      s = idle(); s.v = 1; s.rs1 = 5; s.rfa = 32'h55; s.rd = 6; s.regwen = 1;
      s.pc = 32'h1030;
      apply("after_inv", s, 0, mke(1, 1, 0, 1, 32'h55, 32'h0, 6, 32'h1030));

      // Async reset while stalling
      lw7.pc = 32'h1034;
      apply("lw7b", lw7, 0, mke(1, 1, 1, 1, 32'h200, 32'h0, 7, 32'h1034));
      drive(dep7);
      #1;
      chk("pre_rst.stall_out", {31'd0, stall_out}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst.ex_valid",   {31'd0, ex_valid},   32'd0);
      chk("async_rst.ex_memread", {31'd0, ex_memread}, 32'd0);
      chk("async_rst.ex_regwen",  {31'd0, ex_regwen},  32'd0);
      chk("async_rst.ex_rd",      {27'd0, ex_rd},      32'd0);
      chk("async_rst.ex_opa",     ex_opa, 32'd0);
      chk("async_rst.ex_pc",      ex_pc,  32'd0);
      chk("async_rst.stall_out",  {31'd0, stall_out}, 32'd0);
      sb_q.push_back(mke(0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0));
      @(posedge clk);
      #2;
      sb_q.push_back(mke(0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0));
      @(posedge clk);
      #2;
      rst = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt_rst", stall_cnt, 32'd0);
`endif
      // Recovery after reset: the dependent instruction flows without stall
      apply("post_rst", dep7, 0, mke(1, 1, 0, 1, 32'h11, 32'hDEAD, 9, 32'h1018));

      drive(idle());
      repeat (2) @(posedge clk);
      #3;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
